// File: rtl/afe_flag_pkg.sv
// afe_flag_pkg: record layout constants, event FSM states and record assembly.
package afe_flag_pkg;

    localparam int CHID_LSB = 24;
    localparam int FLAG_LSB = 16;
    localparam int PTR_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        PENDING  = 2'd2
    } flag_state_e;

    // Fields arrive zero-extended, so unused record bits stay 0.
    function automatic logic [31:0] make_record(input logic [7:0] chid,
                                                input logic [7:0] flags,
                                                input logic [15:0] ptr);
        logic [31:0] r;
        r = '0;
        r[CHID_LSB +: 8] = chid;
        r[FLAG_LSB +: 8] = flags;
        r[PTR_LSB +: 16] = ptr;
        return r;
    endfunction

endpackage

// File: rtl/afe_flag_fifo.sv
// afe_flag_fifo: synchronous FIFO with flush, full/empty and fill count.
module afe_flag_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      fill_q, fill_d;
    logic             do_push, do_pop;

    assign full_o  = fill_q == (AW+1)'(DEPTH);
    assign empty_o = fill_q == '0;
    assign fill_o  = fill_q;
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot the same-cycle push needs when full.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        fill_d = fill_q;
        if (flush_i) begin
            wr_d   = '0;
            rd_d   = '0;
            fill_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = data_i;
                wr_d        = wr_q + 1'b1;
            end
            rd_d   = do_pop ? rd_q + 1'b1 : rd_q;
            fill_d = fill_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/afe_flag_queue.sv
// afe_flag_queue: qualifies AFE readout flags per channel, queues flag records
// and raises a threshold event with drop/overflow statistics.
module afe_flag_queue
    import afe_flag_pkg::*;
#(
    parameter int AFE_NUM_CHS    = 8,
    parameter int AFE_CHID_WIDTH = 4,
    parameter int AFE_FLAG_WIDTH = 4,
    parameter int L2_TRANS_SIZE  = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int CNT_WIDTH      = 6
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  smpl_valid_i,
    input  logic [AFE_CHID_WIDTH-1:0]             smpl_chid_i,
    input  logic [AFE_FLAG_WIDTH-1:0]             smpl_flags_i,
    input  logic [L2_TRANS_SIZE-1:0]              smpl_wr_ptr_i,
    input  logic                                  cfg_en_i,
    input  logic [AFE_NUM_CHS-1:0]                cfg_ch_en_i,
    input  logic [AFE_NUM_CHS*AFE_FLAG_WIDTH-1:0] cfg_flag_mask_i,
    input  logic [CNT_WIDTH-1:0]                  cfg_thresh_i,
    input  logic                                  cfg_clr_i,
    input  logic                                  cfg_evt_clr_i,
    output logic                                  flag_valid_o,
    input  logic                                  flag_ready_i,
    output logic [31:0]                           flag_data_o,
    output logic                                  flag_event_o,
    output logic [$clog2(FIFO_DEPTH):0]           fill_o,
    output logic [CNT_WIDTH-1:0]                  drop_cnt_o,
    output logic                                  ovfl_o
);

    logic [AFE_NUM_CHS-1:0] ch_hit;
    logic                   qual, pop, full, empty, accepted, dropped;
    logic [CNT_WIDTH-1:0]   thresh, cnt_inc;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, drop_q, drop_d;
    logic                   ovfl_q, ovfl_d, evt_q, evt_d;
    flag_state_e            state_q, state_d;

    // Per-channel match avoids indexing with an out-of-range chid.
    for (genvar c = 0; c < AFE_NUM_CHS; c++) begin : g_ch
        assign ch_hit[c] = (smpl_chid_i == AFE_CHID_WIDTH'(c)) & cfg_ch_en_i[c]
                         & |(smpl_flags_i & cfg_flag_mask_i[c*AFE_FLAG_WIDTH +: AFE_FLAG_WIDTH]);
    end

    assign qual     = smpl_valid_i & cfg_en_i & |ch_hit;
    assign pop      = flag_valid_o & flag_ready_i;
    assign accepted = qual & (~full | pop) & ~cfg_clr_i;
    assign dropped  = qual & full & ~pop & ~cfg_clr_i;
    assign thresh   = (cfg_thresh_i == '0) ? CNT_WIDTH'(1) : cfg_thresh_i;
    assign cnt_inc  = (accepted && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    afe_flag_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (cfg_clr_i),
        .push_i  (qual),
        .pop_i   (flag_ready_i),
        .data_i  (make_record(8'(smpl_chid_i), 8'(smpl_flags_i), 16'(smpl_wr_ptr_i))),
        .data_o  (flag_data_o),
        .full_o  (full),
        .empty_o (empty),
        .fill_o  (fill_o)
    );

    assign flag_valid_o = ~empty;
    assign flag_event_o = evt_q;
    assign drop_cnt_o   = drop_q;
    assign ovfl_o       = ovfl_q;

    always_comb begin
        drop_d = drop_q;
        ovfl_d = ovfl_q;
        if (cfg_clr_i) begin
            drop_d = '0;
            ovfl_d = 1'b0;
        end else if (dropped) begin
            drop_d = (&drop_q) ? drop_q : drop_q + 1'b1;
            ovfl_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        evt_d   = 1'b0;
        if (cfg_clr_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == PENDING) begin
            if (cfg_evt_clr_i) begin
                cnt_d = CNT_WIDTH'(accepted);
                if (cnt_d >= thresh) evt_d = 1'b1;
                else state_d = accepted ? COUNTING : IDLE;
            end
        end else if (cnt_inc >= thresh) begin
            state_d = PENDING;
            evt_d   = 1'b1;
        end else if (accepted) begin
            state_d = COUNTING;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= '0;
            ovfl_q  <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            ovfl_q  <= ovfl_d;
            evt_q   <= evt_d;
        end
    end

endmodule
